// File: rtl/ysyx_23060201_pcu.sv
// ---------------------------------------------------------------------------
// ysyx_23060201_pcu -- program-counter unit for the multi-cycle core.
//
// Holds the architectural PC and offers it to instruction fetch over a
// valid/ready handshake. Only one instruction is in flight at a time: after a
// fetch is accepted the unit waits for write-back to commit. The commit then
// selects the next PC (pc+4, a redirect target, or a halt).
//
// Ports:
//   clk            single clock, rising edge
//   rst_n          synchronous active-low reset
//   pc             PC presented to fetch
//   pc_valid       pc is valid for fetch (decoded from state)
//   pc_ready       fetch accepts pc; fire = pc_valid & pc_ready
//   commit_valid   one-cycle pulse: in-flight instruction retired
//   redirect_valid qualifies redirect_pc (sampled only with commit_valid)
//   redirect_pc    jump/branch/trap target
//   halt_req       retiring instruction is ebreak (sampled with commit_valid)
//   halted         unit is parked in HALT
//   misalign       misaligned redirect detected (sticky until reset)
//   fetch_cnt      number of accepted fetches since reset (wraps)
//
// Build option: YSYX_23060201_PCU_MISALIGN_CHK_EN
//   defined   -> a redirect with redirect_pc[1:0] != 0 parks the unit in HALT
//                with misalign=1 and the old pc kept.
//   undefined -> the redirect target is word-aligned by clearing bits [1:0];
//                misalign is tied to 0.
// ---------------------------------------------------------------------------
module ysyx_23060201_pcu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] pc,
  output logic        pc_valid,
  input  logic        pc_ready,
  input  logic        commit_valid,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt_req,
  output logic        halted,
  output logic        misalign,
  output logic [31:0] fetch_cnt
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t      state, state_next;
  logic [31:0] pc_q, pc_next;
  logic [31:0] cnt_q, cnt_next;
`ifdef YSYX_23060201_PCU_MISALIGN_CHK_EN
  logic        mis_q, mis_next;
`endif

  // State register and datapath registers. Reset is sampled on the clock edge.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= BOOT;
      pc_q  <= RESET_PC;
      cnt_q <= '0;
`ifdef YSYX_23060201_PCU_MISALIGN_CHK_EN
      mis_q <= 1'b0;
`endif
    end else begin
      state <= state_next;
      pc_q  <= pc_next;
      cnt_q <= cnt_next;
`ifdef YSYX_23060201_PCU_MISALIGN_CHK_EN
      mis_q <= mis_next;
`endif
    end
  end

  // Next-state and next-datapath logic.
  // NOTE: every variable written here gets a hold default first, so no path
  // through the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    pc_next    = pc_q;
    cnt_next   = cnt_q;
`ifdef YSYX_23060201_PCU_MISALIGN_CHK_EN
    mis_next   = mis_q;
`endif
    case (state)
      BOOT: state_next = ISSUE;
      ISSUE: begin
        // pc_valid is 1 throughout ISSUE, so fire reduces to pc_ready.
        if (pc_ready) begin
          cnt_next   = cnt_q + 32'd1;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (commit_valid) begin
          if (halt_req) begin
            state_next = HALT;
          end else if (redirect_valid) begin
`ifdef YSYX_23060201_PCU_MISALIGN_CHK_EN
            if (redirect_pc[1:0] != 2'b00) begin
              mis_next   = 1'b1;
              state_next = HALT;
            end else begin
              pc_next    = redirect_pc;
              state_next = ISSUE;
            end
`else
            pc_next    = redirect_pc & 32'hFFFF_FFFC;
            state_next = ISSUE;
`endif
          end else begin
            pc_next    = pc_q + 32'd4;
            state_next = ISSUE;
          end
        end
      end
      HALT: state_next = HALT;
      default: state_next = BOOT;
    endcase
  end

  // Outputs come straight from registers or from the state decode, so there
  // is no combinational path from any input to any output.
  assign pc        = pc_q;
  assign fetch_cnt = cnt_q;
  assign pc_valid  = (state == ISSUE);
  assign halted    = (state == HALT);
`ifdef YSYX_23060201_PCU_MISALIGN_CHK_EN
  assign misalign  = mis_q;
`else
  assign misalign  = 1'b0;
`endif

endmodule

// File: tb/tb_ysyx_23060201_pcu.sv
// ---------------------------------------------------------------------------
// tb_ysyx_23060201_pcu -- directed self-checking bench for ysyx_23060201_pcu.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_ysyx_23060201_pcu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc;
  logic        pc_valid;
  logic        pc_ready;
  logic        commit_valid;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt_req;
  logic        halted;
  logic        misalign;
  logic [31:0] fetch_cnt;

  int n_checks = 0;
  int n_errors = 0;

  ysyx_23060201_pcu dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pc             (pc),
    .pc_valid       (pc_valid),
    .pc_ready       (pc_ready),
    .commit_valid   (commit_valid),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt_req       (halt_req),
    .halted         (halted),
    .misalign       (misalign),
    .fetch_cnt      (fetch_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expects the unit in ISSUE with exp_pc; performs one fire and lands in WAIT.
  task automatic do_fire(input string tag, input logic [31:0] exp_pc);
    check({tag, ".valid"}, {31'd0, pc_valid}, 32'd1);
    check({tag, ".pc"}, pc, exp_pc);
    pc_ready = 1'b1;
    tick();
    pc_ready = 1'b0;
    check({tag, ".wait_valid"}, {31'd0, pc_valid}, 32'd0);
  endtask

  task automatic do_commit(input logic rv, input logic [31:0] rpc, input logic h);
    commit_valid   = 1'b1;
    redirect_valid = rv;
    redirect_pc    = rpc;
    halt_req       = h;
    tick();
    commit_valid   = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    halt_req       = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".pc"}, pc, 32'h8000_0000);
    check({tag, ".valid"}, {31'd0, pc_valid}, 32'd0);
    check({tag, ".cnt"}, fetch_cnt, 32'd0);
    check({tag, ".halted"}, {31'd0, halted}, 32'd0);
    check({tag, ".misalign"}, {31'd0, misalign}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; pc_ready = 1'b0; commit_valid = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'd0; halt_req = 1'b0;
    #1;
    tick();
    tick();
    check_reset_state("reset");

    // Release: BOOT cycle first, pc_valid one cycle later.
    rst_n = 1'b1;
    check("boot_valid", {31'd0, pc_valid}, 32'd0);
    tick();
    check("first_valid", {31'd0, pc_valid}, 32'd1);

    // Backpressure: pc and pc_valid hold for 5 cycles, no count.
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp.pc", pc, 32'h8000_0000);
      check("bp.valid", {31'd0, pc_valid}, 32'd1);
      check("bp.cnt", fetch_cnt, 32'd0);
    end
    do_fire("seq0", 32'h8000_0000);
    check("bp.cnt_after", fetch_cnt, 32'd1);

    // Sequential stream.
    do_commit(1'b0, 32'd0, 1'b0);
    do_fire("seq1", 32'h8000_0004);
    do_commit(1'b0, 32'd0, 1'b0);
    do_fire("seq2", 32'h8000_0008);
    check("seq.cnt3", fetch_cnt, 32'd3);

    // redirect_valid without commit_valid is ignored.
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0100;
    tick();
    redirect_valid = 1'b0; redirect_pc = 32'd0;
    check("rv_nocommit.valid", {31'd0, pc_valid}, 32'd0);
    check("rv_nocommit.pc", pc, 32'h8000_0008);
    do_commit(1'b0, 32'd0, 1'b0);
    check("rv_nocommit.next", pc, 32'h8000_000C);

    // commit_valid in ISSUE is ignored.
    do_commit(1'b1, 32'h1234_0000, 1'b0);
    check("commit_in_issue.pc", pc, 32'h8000_000C);
    check("commit_in_issue.valid", {31'd0, pc_valid}, 32'd1);
    do_fire("seq3", 32'h8000_000C);

    // Redirect, then wrap.
    do_commit(1'b1, 32'h8000_0100, 1'b0);
    do_fire("redir", 32'h8000_0100);
    do_commit(1'b1, 32'hFFFF_FFFC, 1'b0);
    do_fire("top", 32'hFFFF_FFFC);
    do_commit(1'b0, 32'd0, 1'b0);
    do_fire("wrap", 32'h0000_0000);
    check("wrap.cnt", fetch_cnt, 32'd7);

    // Misaligned redirect.
    do_commit(1'b1, 32'h8000_0102, 1'b0);
`ifdef YSYX_23060201_PCU_MISALIGN_CHK_EN
    check("mis.halted", {31'd0, halted}, 32'd1);
    check("mis.misalign", {31'd0, misalign}, 32'd1);
    check("mis.valid", {31'd0, pc_valid}, 32'd0);
    check("mis.pc", pc, 32'h0000_0000);
`else
    check("mis.misalign", {31'd0, misalign}, 32'd0);
    check("mis.halted", {31'd0, halted}, 32'd0);
    do_fire("mis_align", 32'h8000_0100);
    check("mis.cnt", fetch_cnt, 32'd8);
`endif

    // Fresh reset, then halt with redirect also asserted.
    rst_n = 1'b0;
    tick();
    check_reset_state("reset2");
    rst_n = 1'b1;
    tick();
    do_fire("h0", 32'h8000_0000);
    do_commit(1'b1, 32'h1234_5678, 1'b1);
    check("halt.halted", {31'd0, halted}, 32'd1);
    check("halt.valid", {31'd0, pc_valid}, 32'd0);
    check("halt.pc", pc, 32'h8000_0000);
    pc_ready = 1'b1;
    do_commit(1'b0, 32'd0, 1'b0);
    do_commit(1'b1, 32'h4000_0000, 1'b0);
    tick();
    pc_ready = 1'b0;
    check("halt_hold.halted", {31'd0, halted}, 32'd1);
    check("halt_hold.valid", {31'd0, pc_valid}, 32'd0);
    check("halt_hold.pc", pc, 32'h8000_0000);
    check("halt_hold.cnt", fetch_cnt, 32'd1);

    // Reset in HALT.
    rst_n = 1'b0;
    tick();
    check_reset_state("reset_halt");
    rst_n = 1'b1;
    tick();
    check("post_halt.valid", {31'd0, pc_valid}, 32'd1);

    // Reset while in WAIT; the commit right after is ignored.
    do_fire("m0", 32'h8000_0000);
    do_commit(1'b0, 32'd0, 1'b0);
    do_fire("m1", 32'h8000_0004);
    check("mid.cnt", fetch_cnt, 32'd2);
    rst_n = 1'b0;
    tick();
    check_reset_state("reset_wait");
    rst_n = 1'b1;
    do_commit(1'b1, 32'h4000_0000, 1'b0);
    check("mid.first_valid", {31'd0, pc_valid}, 32'd1);
    check("mid.first_pc", pc, 32'h8000_0000);
    check("mid.cnt0", fetch_cnt, 32'd0);
    do_fire("m2", 32'h8000_0000);
    check("mid.cnt1", fetch_cnt, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
